// File: rtl/pipeline_arbiter.sv
// ============================================================================
// Module   : pipeline_arbiter
// Brief    : Round-robin front end that shares one ready/valid pipeline among
//            NUM_REQ requesters and steers in-order results back by tag.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipeline_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int TAG_DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ*WIDTH-1:0]       req_data,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [WIDTH-1:0]               pipe_data,
  output logic                           pipe_valid,
  input  logic                           pipe_ready,
  input  logic [WIDTH-1:0]               pipe_result,
  input  logic                           pipe_result_valid,
  output logic                           pipe_result_ready,
  output logic [WIDTH-1:0]               rsp_data,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [$clog2(TAG_DEPTH+1)-1:0] outstanding,
  output logic                           tag_underflow
);

  localparam int c_IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_PW  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int c_OW  = $clog2(TAG_DEPTH + 1);

  typedef enum logic [0:0] {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             r_state;
  logic [c_IDW-1:0]   r_ptr;
  logic [c_IDW-1:0]   r_lock_id;
  logic [c_IDW-1:0]   r_tag_mem [TAG_DEPTH];
  logic [c_PW-1:0]    r_wr_ptr;
  logic [c_PW-1:0]    r_rd_ptr;
  logic [c_OW-1:0]    r_outstanding;
  logic               r_tag_underflow;

  logic [c_IDW-1:0]   w_grant;
  logic [c_IDW-1:0]   w_idx;
  logic               w_any;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_underflow;
  logic [c_IDW-1:0]   w_head;

  // A stalled offer stays locked on its requester so the pipeline sees stable data.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_any   = 1'b0;
    if (r_state == ST_LOCKED) begin
      w_grant = r_lock_id;
      w_any   = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_idx = c_IDW'((int'(r_ptr) + k) % NUM_REQ);
        if (!w_any && req_valid[w_idx]) begin
          w_grant = w_idx;
          w_any   = 1'b1;
        end
      end
    end
  end

  assign w_full     = (r_outstanding == c_OW'(TAG_DEPTH));
  assign w_empty    = (r_outstanding == '0);
  assign pipe_valid = w_any && !w_full;
  assign pipe_data  = req_data[int'(w_grant)*WIDTH +: WIDTH];
  assign w_push     = pipe_valid && pipe_ready;
  assign req_ready  = w_push ? (NUM_REQ'(1) << w_grant) : '0;

  assign w_head            = r_tag_mem[r_rd_ptr];
  assign rsp_data          = pipe_result;
  assign rsp_valid         = (!w_empty && pipe_result_valid) ? (NUM_REQ'(1) << w_head) : '0;
  assign pipe_result_ready = w_empty ? 1'b1 : rsp_ready[w_head];
  assign w_pop             = !w_empty && pipe_result_valid && pipe_result_ready;
  assign w_underflow       = w_empty && pipe_result_valid;

  assign outstanding   = r_outstanding;
  assign tag_underflow = r_tag_underflow;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_tag_mem[r_wr_ptr] <= w_grant;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= ST_OPEN;
      r_ptr           <= '0;
      r_lock_id       <= '0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_outstanding   <= '0;
      r_tag_underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PW'(1);
        r_ptr    <= (w_grant == c_IDW'(NUM_REQ - 1)) ? '0 : w_grant + c_IDW'(1);
        r_state  <= ST_OPEN;
      end else if (pipe_valid) begin
        r_lock_id <= w_grant;
        r_state   <= ST_LOCKED;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_outstanding <= r_outstanding + c_OW'(1);
        2'b01:   r_outstanding <= r_outstanding - c_OW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      if (w_underflow) begin
        r_tag_underflow <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_arbiter.sv
// ============================================================================
// Module   : tb_pipeline_arbiter
// Brief    : Self-checking bench for pipeline_arbiter against a queue model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipeline_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TD = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [N*W-1:0]    req_data = '0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [W-1:0]      pipe_data;
  logic              pipe_valid;
  logic              pipe_ready = 1'b0;
  logic [W-1:0]      pipe_result = '0;
  logic              pipe_result_valid = 1'b0;
  logic              pipe_result_ready;
  logic [W-1:0]      rsp_data;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready = '0;
  logic [2:0]        outstanding;
  logic              tag_underflow;

  pipeline_arbiter #(.NUM_REQ(N), .WIDTH(W), .TAG_DEPTH(TD)) dut (
    .clock(clock), .reset(reset),
    .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .pipe_data(pipe_data), .pipe_valid(pipe_valid), .pipe_ready(pipe_ready),
    .pipe_result(pipe_result), .pipe_result_valid(pipe_result_valid),
    .pipe_result_ready(pipe_result_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .outstanding(outstanding), .tag_underflow(tag_underflow)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of requester IDs awaiting results, plus the
  // round-robin start point and any held (stalled) offer.
  int       m_q[$];
  int       m_ptr = 0;
  bit       m_held = 0;
  int       m_held_id = 0;
  bit       m_underflow = 0;
  int       m_grant;
  bit       m_pv, m_xfer, m_pop, m_uf;
  logic [N-1:0] m_last_rr = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] data_of(input int i);
    return req_data[i*W +: W];
  endfunction

  // Evaluate expectations for the current inputs and compare the DUT outputs.
  task automatic settle();
    logic [N-1:0] e_rr, e_rv;
    logic e_prr;
    bit any;
    int h;
    #3;
    any = 0;
    m_grant = 0;
    if (m_held) begin
      m_grant = m_held_id;
      any = 1;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!any && req_valid[(m_ptr + k) % N]) begin
          m_grant = (m_ptr + k) % N;
          any = 1;
        end
      end
    end
    m_pv   = any && (m_q.size() < TD);
    m_xfer = m_pv && pipe_ready;
    e_rr   = m_xfer ? N'(1 << m_grant) : '0;
    m_uf   = 0;
    m_pop  = 0;
    if (m_q.size() == 0) begin
      e_rv  = '0;
      e_prr = 1'b1;
      m_uf  = pipe_result_valid;
    end else begin
      h     = m_q[0];
      e_rv  = pipe_result_valid ? N'(1 << h) : '0;
      e_prr = rsp_ready[h];
      m_pop = pipe_result_valid && rsp_ready[h];
    end
    check_eq("pipe_valid", 32'(pipe_valid), 32'(m_pv));
    if (m_pv) check_eq("pipe_data", 32'(pipe_data), 32'(data_of(m_grant)));
    check_eq("req_ready", 32'(req_ready), 32'(e_rr));
    check_eq("rsp_valid", 32'(rsp_valid), 32'(e_rv));
    check_eq("pipe_result_ready", 32'(pipe_result_ready), 32'(e_prr));
    check_eq("rsp_data", 32'(rsp_data), 32'(pipe_result));
    check_eq("outstanding", 32'(outstanding), 32'(m_q.size()));
    check_eq("tag_underflow", 32'(tag_underflow), 32'(m_underflow));
    m_last_rr = e_rr;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (m_pop) void'(m_q.pop_front());
    if (m_xfer) begin
      m_q.push_back(m_grant);
      m_ptr  = (m_grant + 1) % N;
      m_held = 0;
    end else if (m_pv) begin
      m_held    = 1;
      m_held_id = m_grant;
    end
    if (m_uf) m_underflow = 1;
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0; pipe_ready = 1'b0; pipe_result_valid = 1'b0; rsp_ready = '0;
    m_last_rr = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    m_q.delete();
    m_ptr = 0; m_held = 0; m_underflow = 0;
    check_eq("reset_outstanding", 32'(outstanding), 32'd0);
    check_eq("reset_underflow", 32'(tag_underflow), 32'd0);
    check_eq("reset_pipe_valid", 32'(pipe_valid), 32'd0);
    check_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
  endtask

  // Requesters keep valid/data stable until accepted, then may drop or reload.
  task automatic rand_inputs();
    for (int i = 0; i < N; i++) begin
      if (m_last_rr[i]) begin
        req_valid[i] = ($urandom % 2) == 0;
        req_data[i*W +: W] = W'($urandom);
      end else if (!req_valid[i] && ($urandom % 3) == 0) begin
        req_valid[i] = 1'b1;
        req_data[i*W +: W] = W'($urandom);
      end
    end
    pipe_ready        = ($urandom % 4) != 0;
    rsp_ready         = N'($urandom);
    pipe_result_valid = (m_q.size() > 0) && (($urandom % 2) == 0);
    pipe_result       = W'($urandom);
  endtask

  int order[$];

  initial begin
    do_reset();

    // Single request and its result.
    req_valid = 4'b0001; req_data[0 +: W] = 8'h10; pipe_ready = 1'b1;
    settle();
    check_eq("t1_pipe_data", 32'(pipe_data), 32'h10);
    check_eq("t1_req_ready", 32'(req_ready), 32'h1);
    tick();
    check_eq("t1_outstanding", 32'(outstanding), 32'd1);
    req_valid = '0; pipe_result = 8'h55; pipe_result_valid = 1'b1; rsp_ready = '1;
    settle();
    check_eq("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("t1_rsp_data", 32'(rsp_data), 32'h55);
    tick();
    check_eq("t1_outstanding_after", 32'(outstanding), 32'd0);

    // Everyone requesting: rotating grant order.
    do_reset();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(8'hA0 + i);
    req_valid = '1; pipe_ready = 1'b1; rsp_ready = '1;
    for (int c = 0; c < 6; c++) begin
      pipe_result_valid = m_q.size() > 0;
      pipe_result = W'(c);
      settle();
      order.push_back(int'(pipe_data) - 'hA0);
      tick();
    end
    for (int c = 0; c < 6; c++) check_eq("t2_grant_order", 32'(order[c]), 32'(c % N));

    // Stalled offer from req2 stays put while req1 joins.
    do_reset();
    pipe_result_valid = 1'b0;
    req_valid = 4'b0100; req_data = 32'h44332211; pipe_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) req_valid[1] = 1'b1;
      settle();
      check_eq("t3_hold_data", 32'(pipe_data), 32'h33);
      tick();
    end
    pipe_ready = 1'b1;
    cycle();
    req_valid = 4'b1011;
    settle(); check_eq("t3_next_req3", 32'(pipe_data), 32'h44); tick();
    req_valid[3] = 1'b0;
    settle(); check_eq("t3_next_req0", 32'(pipe_data), 32'h11); tick();
    req_valid[0] = 1'b0;
    settle(); check_eq("t3_next_req1", 32'(pipe_data), 32'h22); tick();
    req_valid = '0;

    // Fill the tag FIFO, then free one slot.
    do_reset();
    req_valid = '1; pipe_ready = 1'b1;
    for (int c = 0; c < 4; c++) cycle();
    settle();
    check_eq("t4_full_outstanding", 32'(outstanding), 32'd4);
    check_eq("t4_full_pipe_valid", 32'(pipe_valid), 32'd0);
    tick();
    pipe_result_valid = 1'b1; rsp_ready = '1;
    settle();
    check_eq("t4_pop_same_cycle_blocked", 32'(pipe_valid), 32'd0);
    tick();
    pipe_result_valid = 1'b0;
    settle();
    check_eq("t4_resume", 32'(pipe_valid), 32'd1);
    tick();

    // Backpressure from the owning requester (head tag 3).
    do_reset();
    req_valid = 4'b1000; pipe_ready = 1'b1;
    cycle();
    req_valid = '0; pipe_result_valid = 1'b1; rsp_ready = 4'b0111;
    settle();
    check_eq("t5_prr_low", 32'(pipe_result_ready), 32'd0);
    check_eq("t5_rsp_valid", 32'(rsp_valid), 32'h8);
    tick();
    rsp_ready = 4'b1000;
    cycle();
    check_eq("t5_outstanding", 32'(outstanding), 32'd0);

    // Result with no tag, then reset while busy.
    pipe_result_valid = 1'b1;
    settle();
    check_eq("t6_prr_empty", 32'(pipe_result_ready), 32'd1);
    tick();
    pipe_result_valid = 1'b0;
    cycle();
    check_eq("t6_underflow_sticky", 32'(tag_underflow), 32'd1);
    req_valid = 4'b0110;
    cycle(); cycle();
    check_eq("t6_two_outstanding", 32'(outstanding), 32'd2);
    do_reset();
    req_valid = '1; pipe_ready = 1'b0;
    settle();
    check_eq("t6_ptr_zero", 32'(pipe_data), 32'(data_of(0)));
    tick();

    // Randomized traffic with an occasional reset.
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset();
      rand_inputs();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
